// File: rtl/instr_encoder_if.sv
// Loader-side handshake bundle: decoded fields in, encoded word/address out,
// plus the loader status flags.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [3:0]  in_cond;
  logic [1:0]  in_aluop;
  logic        in_s;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [3:0]  in_rm;
  logic [11:0] in_imm12;
  logic [23:0] in_imm24;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;
  logic        full;
  logic        err;

  modport master (
    output in_valid, in_class, in_cond, in_aluop, in_s, in_rn, in_rd, in_rm,
           in_imm12, in_imm24, out_ready,
    input  in_ready, out_valid, out_addr, out_instr, full, err
  );

  modport slave (
    input  in_valid, in_class, in_cond, in_aluop, in_s, in_rn, in_rd, in_rm,
           in_imm12, in_imm24, out_ready,
    output in_ready, out_valid, out_addr, out_instr, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs decoded fields into 32-bit machine words
// and emits them at sequential imem byte addresses through a valid/ready port.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    CLS_DP_REG = 3'd0,
    CLS_DP_IMM = 3'd1,
    CLS_STR    = 3'd2,
    CLS_LDR    = 3'd3,
    CLS_B      = 3'd4
  } instr_class_e;

  logic        out_valid_q;
  logic [31:0] out_addr_q;
  logic [31:0] out_instr_q;
  logic        full_q;
  logic        err_q;
  logic [31:0] ptr;
  logic [31:0] count;

  logic [3:0]  cmd;
  logic [31:0] word;
  logic        legal;
  logic        accept;

  always_comb begin
    unique case (bus.in_aluop)
      2'b00:   cmd = 4'b0100;
      2'b01:   cmd = 4'b0010;
      2'b10:   cmd = 4'b0000;
      default: cmd = 4'b1100;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (bus.in_class)
      CLS_DP_REG: word = {bus.in_cond, 2'b00, 1'b0, cmd, bus.in_s, bus.in_rn,
                          bus.in_rd, 8'h00, bus.in_rm};
      CLS_DP_IMM: word = {bus.in_cond, 2'b00, 1'b1, cmd, bus.in_s, bus.in_rn,
                          bus.in_rd, bus.in_imm12};
      CLS_STR:    word = {bus.in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0,
                          bus.in_rn, bus.in_rd, bus.in_imm12};
      CLS_LDR:    word = {bus.in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1,
                          bus.in_rn, bus.in_rd, bus.in_imm12};
      CLS_B:      word = {bus.in_cond, 2'b10, 2'b10, bus.in_imm24};
      default:    legal = 1'b0;
    endcase
  end

  assign bus.in_ready  = !full_q && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_instr = out_instr_q;
  assign bus.full      = full_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      out_instr_q <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr         <= BASE_ADDR;
      count       <= '0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr         <= BASE_ADDR;
      count       <= '0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      if (accept && legal) begin
        out_valid_q <= 1'b1;
        out_instr_q <= word;
        out_addr_q  <= ptr;
        count       <= count + 32'd1;
        // The last slot's address is kept so the pointer never runs past the window.
        if (count + 32'd1 == DEPTH)
          full_q <= 1'b1;
        else
          ptr <= ptr + 32'd4;
      end
      if (accept && !legal)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (DEPTH 64 and DEPTH 4) share one
// randomized/directed stimulus stream and are scored against a transaction model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  int unsigned f_cls, f_cond, f_aluop, f_s, f_rn, f_rd, f_rm, f_imm12, f_imm24;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_if bus_a ();
  instr_encoder_if bus_b ();

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(64)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_a.slave)
  );
  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_b.slave)
  );

  assign bus_a.in_valid  = in_valid;
  assign bus_a.out_ready = out_ready;
  assign bus_a.in_class  = f_cls[2:0];
  assign bus_a.in_cond   = f_cond[3:0];
  assign bus_a.in_aluop  = f_aluop[1:0];
  assign bus_a.in_s      = f_s[0];
  assign bus_a.in_rn     = f_rn[3:0];
  assign bus_a.in_rd     = f_rd[3:0];
  assign bus_a.in_rm     = f_rm[3:0];
  assign bus_a.in_imm12  = f_imm12[11:0];
  assign bus_a.in_imm24  = f_imm24[23:0];
  assign bus_b.in_valid  = in_valid;
  assign bus_b.out_ready = out_ready;
  assign bus_b.in_class  = f_cls[2:0];
  assign bus_b.in_cond   = f_cond[3:0];
  assign bus_b.in_aluop  = f_aluop[1:0];
  assign bus_b.in_s      = f_s[0];
  assign bus_b.in_rn     = f_rn[3:0];
  assign bus_b.in_rd     = f_rd[3:0];
  assign bus_b.in_rm     = f_rm[3:0];
  assign bus_b.in_imm12  = f_imm12[11:0];
  assign bus_b.in_imm24  = f_imm24[23:0];

  logic [31:0] o_valid[2], o_ready[2], o_full[2], o_err[2], o_addr[2], o_instr[2];
  assign o_valid[0] = 32'(bus_a.out_valid);
  assign o_ready[0] = 32'(bus_a.in_ready);
  assign o_full[0]  = 32'(bus_a.full);
  assign o_err[0]   = 32'(bus_a.err);
  assign o_addr[0]  = bus_a.out_addr;
  assign o_instr[0] = bus_a.out_instr;
  assign o_valid[1] = 32'(bus_b.out_valid);
  assign o_ready[1] = 32'(bus_b.in_ready);
  assign o_full[1]  = 32'(bus_b.full);
  assign o_err[1]   = 32'(bus_b.err);
  assign o_addr[1]  = bus_b.out_addr;
  assign o_instr[1] = bus_b.out_instr;

  // Model: at most one word is pending; n counts words emitted since clear/reset.
  int unsigned depth[2] = '{64, 4};
  int unsigned m_valid[2], m_full[2], m_err[2], m_n[2];
  logic [31:0] m_addr[2], m_instr[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc();
    int unsigned cmd_of[4] = '{4, 2, 0, 12};
    int unsigned w;
    w = f_cond * 32'h1000_0000;
    case (f_cls)
      0: w += cmd_of[f_aluop] * 32'h20_0000 + f_s * 32'h10_0000 + f_rn * 32'h1_0000
              + f_rd * 32'h1000 + f_rm;
      1: w += 32'h200_0000 + cmd_of[f_aluop] * 32'h20_0000 + f_s * 32'h10_0000
              + f_rn * 32'h1_0000 + f_rd * 32'h1000 + f_imm12;
      2, 3: w += 32'h400_0000 + 32'h100_0000 + 32'h80_0000 + (f_cls - 2) * 32'h10_0000
              + f_rn * 32'h1_0000 + f_rd * 32'h1000 + f_imm12;
      default: w += 32'h0A00_0000 + f_imm24;
    endcase
    return w;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_full[d] = 0; m_err[d] = 0; m_n[d] = 0;
    end
  endtask

  // One clock: score both instances mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int unsigned exp_rdy[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = (m_full[d] == 0 && (m_valid[d] == 0 || out_ready)) ? 1 : 0;
      check($sformatf("in_ready[%0d]", d), o_ready[d], exp_rdy[d]);
      check($sformatf("out_valid[%0d]", d), o_valid[d], m_valid[d]);
      check($sformatf("full[%0d]", d), o_full[d], m_full[d]);
      check($sformatf("err[%0d]", d), o_err[d], m_err[d]);
      if (m_valid[d] != 0) begin
        check($sformatf("out_addr[%0d]", d), o_addr[d], m_addr[d]);
        check($sformatf("out_instr[%0d]", d), o_instr[d], m_instr[d]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (clear) begin
        m_valid[d] = 0; m_full[d] = 0; m_err[d] = 0; m_n[d] = 0;
      end else begin
        if (m_valid[d] != 0 && out_ready) m_valid[d] = 0;
        if (in_valid && exp_rdy[d] != 0) begin
          if (f_cls <= 4) begin
            m_valid[d] = 1;
            m_addr[d]  = BASE + 4 * m_n[d];
            m_instr[d] = ref_enc();
            m_n[d]++;
            if (m_n[d] == depth[d]) m_full[d] = 1;
          end else begin
            m_err[d] = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_bundle(input int unsigned cls, input int unsigned cond,
                            input int unsigned aluop, input int unsigned s,
                            input int unsigned rn, input int unsigned rd,
                            input int unsigned rm, input int unsigned imm12,
                            input int unsigned imm24);
    f_cls = cls; f_cond = cond; f_aluop = aluop; f_s = s; f_rn = rn;
    f_rd = rd; f_rm = rm; f_imm12 = imm12; f_imm24 = imm24;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_bundle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", o_valid[0], 0);
    check("rst out_addr", o_addr[0], BASE);
    check("rst out_instr", o_instr[0], 0);
    check("rst full", o_full[0], 0);
    check("rst err", o_err[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_bundle(0, 14, 0, 0, 2, 1, 3, 0, 0); cycle();
    check("dp_reg word", o_instr[0], 32'hE082_1003);
    check("dp_reg addr", o_addr[0], 32'h0);
    set_bundle(1, 14, 0, 0, 2, 1, 0, 5, 0); cycle();
    check("add_imm word", o_instr[0], 32'hE282_1005);
    check("add_imm addr", o_addr[0], 32'h4);
    check("b2b in_ready", o_ready[0], 1);
    set_bundle(1, 14, 1, 1, 0, 0, 0, 1, 0); cycle();
    check("subs word", o_instr[0], 32'hE250_0001);
    check("subs addr", o_addr[0], 32'h8);
    set_bundle(0, 14, 3, 0, 8, 7, 9, 0, 0); cycle();
    check("orr word", o_instr[0], 32'hE188_7009);
    check("orr addr", o_addr[0], 32'hC);
    set_bundle(3, 14, 2, 1, 5, 4, 0, 8, 0); cycle();
    check("ldr word", o_instr[0], 32'hE595_4008);
    set_bundle(2, 14, 3, 1, 5, 4, 0, 8, 0); cycle();
    check("str word", o_instr[0], 32'hE585_4008);
    set_bundle(4, 14, 3, 1, 5, 4, 7, 8, 24'hFF_FFFE); cycle();
    check("b word", o_instr[0], 32'hEAFF_FFFE);
    check("b addr", o_addr[0], 32'h18);

    out_ready = 1'b0;
    set_bundle(0, 1, 1, 1, 3, 3, 3, 0, 0);
    repeat (3) begin
      cycle();
      check("stall word", o_instr[0], 32'hEAFF_FFFE);
      check("stall addr", o_addr[0], 32'h18);
      check("stall in_ready", o_ready[0], 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    cycle();

    in_valid = 1'b1;
    set_bundle(6, 14, 0, 0, 1, 1, 1, 0, 0); cycle();
    in_valid = 1'b0;
    check("illegal err", o_err[0], 1);
    check("illegal no word", o_valid[0], 0);
    cycle();
    in_valid = 1'b1;
    set_bundle(0, 14, 0, 0, 2, 1, 3, 0, 0); cycle();
    in_valid = 1'b0;
    check("after illegal addr", o_addr[0], 32'h1C);
    cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    check("clear err", o_err[0], 0);
    in_valid = 1'b1; cycle(); in_valid = 1'b0;
    check("after clear addr", o_addr[0], BASE);
    cycle();

    clear = 1'b1; cycle(); clear = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_bundle(0, 14, i % 4, 0, i, i, i, 0, 0);
      cycle();
    end
    check("depth4 full", o_full[1], 1);
    check("depth4 in_ready", o_ready[1], 0);
    check("depth4 last addr", o_addr[1], 32'hC);
    cycle();
    check("depth4 drained", o_valid[1], 0);
    clear = 1'b1; cycle(); clear = 1'b0; in_valid = 1'b0;
    check("clear+valid dropped", o_valid[1], 0);
    check("clear full", o_full[1], 0);
    cycle();

    repeat (400) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      clear     = ($urandom_range(49) == 0);
      f_cls     = ($urandom_range(15) == 0) ? $urandom_range(7, 5) : $urandom_range(4);
      f_cond    = $urandom_range(15);
      f_aluop   = $urandom_range(3);
      f_s       = $urandom_range(1);
      f_rn      = $urandom_range(15);
      f_rd      = $urandom_range(15);
      f_rm      = $urandom_range(15);
      f_imm12   = $urandom_range(4095);
      f_imm24   = $urandom & 32'h00FF_FFFF;
      cycle();
    end
    clear = 1'b0;

    clear = 1'b1; cycle(); clear = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(3, 14, 0, 0, 5, 4, 0, 8, 0); cycle();
    in_valid = 1'b0;
    check("pre-reset valid", o_valid[0], 1);
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    check("async rst valid a", o_valid[0], 0);
    check("async rst addr a", o_addr[0], BASE);
    check("async rst valid b", o_valid[1], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming instruction encoder, the inverse of the control decoder. It packs decoded instruction fields (class, cond, ALU op, S bit, registers, immediates) into 32-bit machine words in the decoder's format, assigns each word a sequential instruction-memory address, and writes it through a valid/ready port. It serves as the program loader in front of imem for self-checking CPU benches and boot-time loading.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of first emitted word
DEPTH, 64, maximum words emitted before full (1..2^30)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous restart: address pointer to BASE_ADDR, drop pending word, clear full/err
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid&in_ready
in_class  in  3  0 DP-reg, 1 DP-imm, 2 STR, 3 LDR, 4 B, 5-7 illegal
in_cond  in  4  condition field [31:28]
in_aluop  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR (same code as ALUControl)
in_s  in  1  set-flags bit (DP only)
in_rn  in  4  first source / base register
in_rd  in  4  destination / store-data register
in_rm  in  4  second source register (DP-reg)
in_imm12  in  12  DP-imm {rot4,imm8} or LDR/STR offset
in_imm24  in  24  branch offset
out_valid  out  1  word/address valid toward imem
out_ready  in  1  imem accepts when out_valid&out_ready
out_addr  out  32  byte address of word
out_instr  out  32  encoded word
full  out  1  DEPTH words captured
err  out  1  sticky: illegal class seen

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_addr=BASE_ADDR, out_instr=0, full=0, err=0, pointer=BASE_ADDR, count=0.
- in_ready = !full & (!out_valid | out_ready) (combinational; single output register, full throughput).
- Accept: word encoded combinationally, registered into out_instr and out_addr=pointer with out_valid=1; latency 1 cycle. Pointer += 4, count += 1. Inputs must not be sampled when not accepted.
- out_valid stays 1 and out_instr/out_addr stay stable until out_ready; out_valid drops the cycle after a transfer with no new accept.
- Encoding (bits [31:28] = in_cond for all classes):
  - DP-reg: [27:26]=00, [25]=0, [24:21]=cmd, [20]=in_s, [19:16]=rn, [15:12]=rd, [11:4]=0, [3:0]=rm.
  - DP-imm: same as DP-reg, but [25]=1 and [11:0]=imm12.
  - cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100.
  - STR/LDR: [27:26]=01, [25]=0, [24]=1 (P), [23]=1 (U), [22:21]=00, [20]=0 STR / 1 LDR, rn, rd, imm12. in_aluop and in_s are ignored.
  - B: [27:26]=10, [25:24]=10, [23:0]=imm24. Other fields are ignored.
- Illegal class (5-7): the bundle is accepted (handshake completes). No word is emitted; pointer and count are unchanged. err set, held until clear or reset.
- full: asserted the cycle count reaches DEPTH, which forces in_ready=0. The pending word still drains normally. Pointer does not advance past BASE_ADDR+4*(DEPTH-1). No wrap.
- clear has priority over everything in the same cycle. Any accept that cycle is discarded, out_valid<=0, pointer=BASE_ADDR, count=0, full=0, err=0.
- Reset asserted mid-transfer aborts the pending word immediately (out_valid=0).

Test Plan:
- Reset, then class0 cond=E aluop=00 rn=2 rd=1 rm=3 s=0, out_ready=1 -> next cycle out_valid=1, out_instr=E0821003, out_addr=0.
- Back-to-back, out_ready=1:
  - DP-imm ADD R1,R2,#5 -> E2821005 @4
  - SUBS R0,R0,#1 -> E2500001 @8
  - ORR R7,R8,R9 -> E1887009 @C
  - Check one word per cycle, in_ready held 1.
- LDR R4,[R5,#8] -> E5954008; STR same fields -> E5854008; B imm24=FFFFFE -> EAFFFFFE. With out_ready=0 for 3 cycles: out_instr/out_addr stable, in_ready=0, no pointer change.
- Send class=6 -> err=1, no out_valid pulse, next legal word still gets the next address. Assert clear -> err=0, next word at BASE_ADDR.
- DEPTH=4: send 5 bundles -> 4 words at 0,4,8,C, full=1, in_ready=0 for the 5th. Clear and in_valid in the same cycle -> bundle dropped, full=0.
- Assert reset_n low asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 immediately, out_addr=BASE_ADDR.
